xilinx_macro_ram_sdp: RTL and testbench
=======================================

XILINX_MACRO_RAM_SDP -- requirements
Module: xilinx_macro_ram_sdp

Interface
REQ-001 Parameter ADDR_WIDTH, default 4: address bits; depth = 2**ADDR_WIDTH words.
REQ-002 Parameter DATA_WIDTH, default 64: word width; SHALL be a multiple of BYTE_WIDTH.
REQ-003 Parameter BYTE_WIDTH, default 8: byte-lane width; NB = DATA_WIDTH/BYTE_WIDTH lanes.
REQ-004 Parameter RD_LATENCY, default 1: read latency in cycles; legal values 1 or 2.
REQ-005 Parameter WRITE_MODE, default 0: same-address collision policy; 0 = READ_FIRST, 1 = WRITE_FIRST.
REQ-006 Parameter INIT_CLEAR, default 1: 1 = zero the whole array after reset.
REQ-007 The block SHALL use one clock, clk, and a synchronous, active-high reset, rst.
REQ-008 clk  in  1  clock; all state changes on the rising edge.
REQ-009 rst  in  1  synchronous active-high reset.
REQ-010 we  in  1  write request.
REQ-011 wbe  in  NB  byte-lane write enables.
REQ-012 waddr  in  ADDR_WIDTH  write address.
REQ-013 din  in  DATA_WIDTH  write data.
REQ-014 re  in  1  read request.
REQ-015 raddr  in  ADDR_WIDTH  read address.
REQ-016 dout  out  DATA_WIDTH  read data.
REQ-017 dout_valid  out  1  one-cycle pulse marking new dout.
REQ-018 busy  out  1  high while the init clear runs; requests are ignored.

Function
REQ-019 The controller SHALL have two states: INIT (clear sweep) and READY.
REQ-020 Leaving reset, the controller SHALL enter INIT if INIT_CLEAR=1 and READY otherwise.
REQ-021 In INIT, each cycle SHALL write zero to address cnt and then increment cnt from 0 to 2**ADDR_WIDTH-1.
REQ-022 After cnt = 2**ADDR_WIDTH-1 is written, the controller SHALL go to READY; busy is high for exactly 2**ADDR_WIDTH cycles.
REQ-023 While busy=1, we and re SHALL be ignored: no array write, no dout_valid.
REQ-024 In READY, a write with we=1 SHALL update lane k of word waddr with din lane k only where wbe[k]=1; other lanes are kept.
REQ-025 we=1 with wbe all zero SHALL leave the array unchanged.
REQ-026 A read with re=1 sampled at edge t SHALL present data on dout, with dout_valid=1, after edge t+RD_LATENCY-1, i.e. during cycle t+RD_LATENCY.
REQ-027 Back-to-back reads SHALL be accepted every cycle at full throughput.
REQ-028 dout SHALL hold its last value when no read completes; dout_valid SHALL be 0 in those cycles.
REQ-029 On we=1 and re=1 to the same address: READ_FIRST returns the old word; WRITE_FIRST returns the old word merged with the enabled din lanes.
REQ-030 Reads and writes to different addresses in the same cycle SHALL be independent.
REQ-031 Address wrap is not applicable: all addresses are in range by width.

Reset
REQ-032 rst=1 SHALL force dout=0, dout_valid=0, any in-flight read to be discarded, and cnt=0.
REQ-033 After rst, busy SHALL be 1 if INIT_CLEAR=1 and 0 otherwise.
REQ-034 rst asserted mid-INIT SHALL restart the sweep at address 0.
REQ-035 Array contents SHALL be changed only by the INIT sweep, never directly by rst.
REQ-036 A write presented in the same cycle as rst SHALL be dropped.

Structure
REQ-037 A shared package xilinx_macro_ram_pkg SHALL hold the WRITE_MODE constants (WM_READ_FIRST=0, WM_WRITE_FIRST=1) and the state encoding (ST_INIT, ST_READY).
REQ-038 The INIT/READY FSM and cnt SHALL live in one sub-module, xilinx_macro_ram_init_ctrl, which outputs busy and the clear address.
REQ-039 The array SHALL be written in an inferable block-RAM style: registered read, optional second output register when RD_LATENCY=2.

Verification (ADDR_WIDTH=4, DATA_WIDTH=32, BYTE_WIDTH=8 unless noted)
REQ-040 Init: release rst with INIT_CLEAR=1 -> busy high 16 cycles; then reading addr 0..15 returns 0x00000000.
REQ-041 Byte enables: write 0x11223344 to addr 3, then wbe=4'b0101 with din 0xAABBCCDD -> read addr 3 returns 0x11BB33DD.
REQ-042 Latency: re at addr 3 at cycle t -> dout_valid at t+1 for RD_LATENCY=1 and at t+2 for RD_LATENCY=2; streaming 16 reads gives 16 consecutive valid pulses.
REQ-043 Collision: addr 5 holds 0x0; same-cycle write 0xCAFEF00D (wbe=4'hF) and read of addr 5 -> 0x00000000 (READ_FIRST) or 0xCAFEF00D (WRITE_FIRST).
REQ-044 Reset mid-init: assert rst at sweep cycle 7 -> busy stays high 16 more cycles after release; we/re ignored throughout.
REQ-045 Reset mid-read: re at t, rst at t+1 with RD_LATENCY=2 -> dout=0, no dout_valid pulse.

Source files
------------

// File: rtl/xilinx_macro_ram_pkg.sv
// Shared constants for the simple-dual-port macro RAM: collision policy and controller states.
package xilinx_macro_ram_pkg;

    localparam int unsigned WM_READ_FIRST  = 0;
    localparam int unsigned WM_WRITE_FIRST = 1;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_e;

endpackage

// File: rtl/xilinx_macro_ram_init_ctrl.sv
// Post-reset clear sequencer: sweeps every address once with zero, then reports READY.
module xilinx_macro_ram_init_ctrl
    import xilinx_macro_ram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned INIT_CLEAR = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  busy_o,
    output logic [ADDR_WIDTH-1:0] clr_addr_o
);

    localparam logic [ADDR_WIDTH-1:0] CNT_LAST = '1;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] cnt_q;
    logic                  busy_q;

    // busy is kept as its own flop so it leaves the block registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= (INIT_CLEAR != 0) ? ST_INIT : ST_READY;
            cnt_q   <= '0;
            busy_q  <= (INIT_CLEAR != 0);
        end else begin
            case (state_q)
                ST_INIT: begin
                    cnt_q <= cnt_q + ADDR_WIDTH'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_q <= ST_READY;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o     = busy_q;
    assign clr_addr_o = cnt_q;

endmodule

// File: rtl/xilinx_macro_ram_sdp.sv
// Simple-dual-port block RAM with byte-lane writes, 1- or 2-cycle registered read and
// an optional zero-fill sweep after reset.
module xilinx_macro_ram_sdp
    import xilinx_macro_ram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned BYTE_WIDTH = 8,
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned WRITE_MODE = 0,
    parameter int unsigned INIT_CLEAR = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               we,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]   wbe,
    input  logic [ADDR_WIDTH-1:0]              waddr,
    input  logic [DATA_WIDTH-1:0]              din,
    input  logic                               re,
    input  logic [ADDR_WIDTH-1:0]              raddr,
    output logic [DATA_WIDTH-1:0]              dout,
    output logic                               dout_valid,
    output logic                               busy
);

    localparam int unsigned NB    = DATA_WIDTH / BYTE_WIDTH;
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  wr_en;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] s1_data_q;
    logic                  s1_valid_q;

    xilinx_macro_ram_init_ctrl #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .INIT_CLEAR (INIT_CLEAR)
    ) u_init_ctrl (
        .clk        (clk),
        .rst        (rst),
        .busy_o     (busy),
        .clr_addr_o (clr_addr)
    );

    assign wr_en = we & ~busy & ~rst;
    assign rd_en = re & ~busy;

    // WRITE_FIRST forwards the enabled incoming lanes on a same-address collision
    always_comb begin
        rd_word = mem[raddr];
        if ((WRITE_MODE == WM_WRITE_FIRST) && wr_en && (waddr == raddr)) begin
            for (int unsigned k = 0; k < NB; k++) begin
                if (wbe[k]) begin
                    rd_word[k*BYTE_WIDTH +: BYTE_WIDTH] = din[k*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // Array port: sweep clear takes priority; reset itself never touches contents
    always_ff @(posedge clk) begin
        if (busy && !rst) begin
            mem[clr_addr] <= '0;
        end else if (wr_en) begin
            for (int unsigned k = 0; k < NB; k++) begin
                if (wbe[k]) begin
                    mem[waddr][k*BYTE_WIDTH +: BYTE_WIDTH] <= din[k*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_data_q  <= '0;
            s1_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= rd_en;
            if (rd_en) begin
                s1_data_q <= rd_word;
            end
        end
    end

    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic [DATA_WIDTH-1:0] dout_q;
            logic                  valid_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    dout_q  <= '0;
                    valid_q <= 1'b0;
                end else begin
                    valid_q <= s1_valid_q;
                    if (s1_valid_q) begin
                        dout_q <= s1_data_q;
                    end
                end
            end

            assign dout       = dout_q;
            assign dout_valid = valid_q;
        end else begin : g_lat1
            assign dout       = s1_data_q;
            assign dout_valid = s1_valid_q;
        end
    endgenerate

endmodule

// File: tb/tb_xilinx_macro_ram_sdp.sv
// Drives a READ_FIRST/latency-1 and a WRITE_FIRST/latency-2 instance with identical stimulus.
module tb_xilinx_macro_ram_sdp;

    localparam int unsigned AW    = 4;
    localparam int unsigned DW    = 32;
    localparam int unsigned NBL   = 4;
    localparam int          DEPTH = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic           we;
    logic [NBL-1:0] wbe;
    logic [AW-1:0]  waddr;
    logic [DW-1:0]  din;
    logic           re;
    logic [AW-1:0]  raddr;

    logic [DW-1:0]  dout_a, dout_b;
    logic           dout_valid_a, dout_valid_b;
    logic           busy_a, busy_b;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state
    logic [DW-1:0] ref_mem [DEPTH];
    int            busy_left;
    logic [DW-1:0] exp_dout_a, exp_dout_b, pend_d;
    logic          exp_val_a, exp_val_b, pend_v;

    always #5 clk = ~clk;

    xilinx_macro_ram_sdp #(
        .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .BYTE_WIDTH (8),
        .RD_LATENCY (1), .WRITE_MODE (0), .INIT_CLEAR (1)
    ) u_dut_a (
        .clk (clk), .rst (rst), .we (we), .wbe (wbe), .waddr (waddr), .din (din),
        .re (re), .raddr (raddr), .dout (dout_a), .dout_valid (dout_valid_a), .busy (busy_a)
    );

    xilinx_macro_ram_sdp #(
        .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .BYTE_WIDTH (8),
        .RD_LATENCY (2), .WRITE_MODE (1), .INIT_CLEAR (1)
    ) u_dut_b (
        .clk (clk), .rst (rst), .we (we), .wbe (wbe), .waddr (waddr), .din (din),
        .re (re), .raddr (raddr), .dout (dout_b), .dout_valid (dout_valid_b), .busy (busy_b)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                            input logic [NBL-1:0] be);
        logic [DW-1:0] mask;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (old_w & ~mask) | (new_w & mask);
    endfunction

    // One rising edge of the reference behaviour, using the inputs the DUTs just sampled
    task automatic model_edge();
        logic [DW-1:0] old_w, wr_w;
        if (rst) begin
            busy_left  = DEPTH;
            exp_dout_a = '0; exp_val_a = 1'b0;
            exp_dout_b = '0; exp_val_b = 1'b0;
            pend_v     = 1'b0;
        end else begin
            exp_val_b = pend_v;
            if (pend_v) exp_dout_b = pend_d;
            pend_v = 1'b0;
            if (busy_left > 0) begin
                ref_mem[DEPTH - busy_left] = '0;
                busy_left--;
                exp_val_a = 1'b0;
            end else begin
                old_w = ref_mem[raddr];
                wr_w  = merge(ref_mem[waddr], din, wbe);
                exp_val_a = re;
                if (re) begin
                    exp_dout_a = old_w;
                    pend_v     = 1'b1;
                    pend_d     = (we && waddr == raddr) ? wr_w : old_w;
                end
                if (we) ref_mem[waddr] = wr_w;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("busy_a", 64'(busy_a), 64'(busy_left != 0));
        check("busy_b", 64'(busy_b), 64'(busy_left != 0));
        check("valid_a", 64'(dout_valid_a), 64'(exp_val_a));
        check("valid_b", 64'(dout_valid_b), 64'(exp_val_b));
        check("dout_a", 64'(dout_a), 64'(exp_dout_a));
        check("dout_b", 64'(dout_b), 64'(exp_dout_b));
    endtask

    task automatic set_idle();
        we = 1'b0; wbe = '0; waddr = '0; din = '0; re = 1'b0; raddr = '0;
    endtask

    task automatic rand_req();
        we    = 1'($urandom_range(0, 1));
        wbe   = NBL'($urandom);
        waddr = AW'($urandom);
        din   = $urandom;
        re    = 1'($urandom_range(0, 1));
        raddr = AW'($urandom);
    endtask

    // Counts busy cycles from the current (post-reset) cycle onward, with random ignored requests
    task automatic count_busy(input string tag);
        int n;
        n = busy_b ? 1 : 0;
        for (int i = 0; i < 20; i++) begin
            rand_req();
            step();
            if (busy_b) n++;
        end
        set_idle();
        check(tag, 64'(n), 64'd16);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        busy_left = DEPTH;
        exp_dout_a = '0; exp_dout_b = '0; pend_d = '0;
        exp_val_a = 1'b0; exp_val_b = 1'b0; pend_v = 1'b0;
        set_idle();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;

        // Init sweep length, then every word reads zero with back-to-back reads
        count_busy("init_busy_len");
        begin
            int nv;
            nv = 0;
            for (int i = 0; i < DEPTH; i++) begin
                re = 1'b1; raddr = AW'(i);
                step();
                if (i > 0 && dout_valid_b) nv++;
            end
            set_idle();
            step();
            if (dout_valid_b) nv++;
            check("stream_valid_b", 64'(nv), 64'd16);
            step();
        end

        // Byte-lane merge and read latency
        we = 1'b1; wbe = 4'hF; waddr = 4'd3; din = 32'h1122_3344;
        step();
        wbe = 4'b0101; din = 32'hAABB_CCDD;
        step();
        set_idle();
        re = 1'b1; raddr = 4'd3;
        step();
        re = 1'b0;
        check("be_a", 64'(dout_a), 64'h11BB_33DD);
        check("lat_a", 64'(dout_valid_a), 64'd1);
        check("lat_b_early", 64'(dout_valid_b), 64'd0);
        step();
        check("be_b", 64'(dout_b), 64'h11BB_33DD);
        check("lat_b", 64'(dout_valid_b), 64'd1);

        // wbe all zero leaves the word alone
        we = 1'b1; wbe = 4'h0; waddr = 4'd3; din = 32'hFFFF_FFFF;
        step();
        set_idle();
        re = 1'b1; raddr = 4'd3;
        step();
        set_idle();
        check("wbe_zero_a", 64'(dout_a), 64'h11BB_33DD);
        step();

        // Same-address collision
        we = 1'b1; wbe = 4'hF; waddr = 4'd5; din = '0;
        step();
        din = 32'hCAFE_F00D; re = 1'b1; raddr = 4'd5;
        step();
        set_idle();
        check("coll_rf_a", 64'(dout_a), 64'h0);
        step();
        check("coll_wf_b", 64'(dout_b), 64'hCAFE_F00D);
        step();

        // Reset discards an in-flight latency-2 read
        re = 1'b1; raddr = 4'd5;
        step();
        set_idle();
        rst = 1'b1;
        step();
        check("rst_rd_dout_b", 64'(dout_b), 64'h0);
        check("rst_rd_valid_b", 64'(dout_valid_b), 64'd0);
        rst = 1'b0;
        count_busy("post_rst_busy_len");

        // Reset in the middle of the sweep restarts it
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 7; i++) begin
            rand_req();
            step();
        end
        set_idle();
        rst = 1'b1;
        we = 1'b1; wbe = 4'hF; waddr = 4'd9; din = 32'h1234_5678;
        step();
        set_idle();
        rst = 1'b0;
        count_busy("mid_init_busy_len");

        // Random traffic with rare resets
        for (int i = 0; i < 600; i++) begin
            rand_req();
            rst = ($urandom_range(0, 149) == 0);
            step();
        end
        rst = 1'b0;
        set_idle();
        step();
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
